// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, pattern-mode encodings and frame-size helpers.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int CLK_DIV_DEF  = 2;
    localparam int CH_W_DEF     = 1;
    localparam int CHK_LOG2_DEF = 5;
    localparam int CW_DEF       = 10;

    typedef enum logic [1:0] {
        MODE_BLACK = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_SOLID = 2'd3
    } mode_e;

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Pixel-clock divider plus horizontal/vertical position counters.
// tick is combinational: it marks the clk on which the counters advance.
module vga_sync_counter #(
    parameter int H_TOTAL = 800,
    parameter int V_TOTAL = 525,
    parameter int CLK_DIV = 2,
    parameter int CW      = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    output logic          tick,
    output logic [CW-1:0] h_cnt,
    output logic [CW-1:0] v_cnt
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] div_q, div_d;
    logic [CW-1:0] h_q, h_d;
    logic [CW-1:0] v_q, v_d;

    assign tick  = en && (div_q == DW'(CLK_DIV - 1));
    assign h_cnt = h_q;
    assign v_cnt = v_q;

    always_comb begin
        div_d = div_q;
        h_d   = h_q;
        v_d   = v_q;
        if (en) begin
            div_d = tick ? '0 : div_q + 1'b1;
        end
        if (tick) begin
            if (h_q == CW'(H_TOTAL - 1)) begin
                h_d = '0;
                v_d = (v_q == CW'(V_TOTAL - 1)) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= '0;
            h_q   <= '0;
            v_q   <= '0;
        end else begin
            div_q <= div_d;
            h_q   <= h_d;
            v_q   <= v_d;
        end
    end

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA timing generator with registered sync/blanking decode and test patterns.
// Every output is registered one clk after the counter state it describes.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = H_ACTIVE_DEF,
    parameter int   H_FP     = H_FP_DEF,
    parameter int   H_SYNC   = H_SYNC_DEF,
    parameter int   H_BP     = H_BP_DEF,
    parameter int   V_ACTIVE = V_ACTIVE_DEF,
    parameter int   V_FP     = V_FP_DEF,
    parameter int   V_SYNC   = V_SYNC_DEF,
    parameter int   V_BP     = V_BP_DEF,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   CLK_DIV  = CLK_DIV_DEF,
    parameter int   CH_W     = CH_W_DEF,
    parameter int   CHK_LOG2 = CHK_LOG2_DEF,
    parameter int   CW       = CW_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [2:0]        sw,
    output logic              hsync,
    output logic              vsync,
    output logic              video_on,
    output logic [3*CH_W-1:0] rgb,
    output logic [CW-1:0]     pixel_x,
    output logic [CW-1:0]     pixel_y,
    output logic              pixel_tick,
    output logic              frame_end
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int RGB_W   = 3 * CH_W;

    logic          tick;
    logic [CW-1:0] h_cnt, v_cnt;

    vga_sync_counter #(
        .H_TOTAL(H_TOTAL),
        .V_TOTAL(V_TOTAL),
        .CLK_DIV(CLK_DIV),
        .CW     (CW)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .en   (en),
        .tick (tick),
        .h_cnt(h_cnt),
        .v_cnt(v_cnt)
    );

    mode_e             mode_q, mode_d;
    logic              hsync_q, hsync_d;
    logic              vsync_q, vsync_d;
    logic              video_on_q, video_on_d;
    logic [RGB_W-1:0]  rgb_q, rgb_d;
    logic [CW-1:0]     pixel_x_q, pixel_y_q;
    logic              pixel_tick_q, frame_end_q;
    logic              last_pix;
    logic [2:0]        bar_idx;
    logic [2:0]        colour;

    always_comb begin
        hsync_d = ((h_cnt >= CW'(H_ACTIVE + H_FP)) && (h_cnt < CW'(H_ACTIVE + H_FP + H_SYNC)))
                  ? HS_POL : ~HS_POL;
        vsync_d = ((v_cnt >= CW'(V_ACTIVE + V_FP)) && (v_cnt < CW'(V_ACTIVE + V_FP + V_SYNC)))
                  ? VS_POL : ~VS_POL;
        video_on_d = (h_cnt < CW'(H_ACTIVE)) && (v_cnt < CW'(V_ACTIVE));
        last_pix   = (h_cnt == CW'(H_TOTAL - 1)) && (v_cnt == CW'(V_TOTAL - 1));
        mode_d     = (tick && last_pix) ? mode_e'(mode) : mode_q;
    end

    // Threshold compare instead of x*8/H_ACTIVE keeps the bar index divider-free.
    always_comb begin
        bar_idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (h_cnt >= CW'(k * H_ACTIVE / 8)) begin
                bar_idx = 3'(k);
            end
        end
    end

    always_comb begin
        case (mode_q)
            MODE_BARS:  colour = bar_idx;
            MODE_CHECK: colour = {3{h_cnt[CHK_LOG2] ^ v_cnt[CHK_LOG2]}};
            MODE_SOLID: colour = sw;
            default:    colour = 3'd0;
        endcase
        rgb_d = video_on_d ? {{CH_W{colour[2]}}, {CH_W{colour[1]}}, {CH_W{colour[0]}}} : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q       <= MODE_BLACK;
            hsync_q      <= ~HS_POL;
            vsync_q      <= ~VS_POL;
            video_on_q   <= 1'b0;
            rgb_q        <= '0;
            pixel_x_q    <= '0;
            pixel_y_q    <= '0;
            pixel_tick_q <= 1'b0;
            frame_end_q  <= 1'b0;
        end else begin
            mode_q       <= mode_d;
            pixel_tick_q <= tick;
            frame_end_q  <= tick && last_pix;
            if (en) begin
                hsync_q    <= hsync_d;
                vsync_q    <= vsync_d;
                video_on_q <= video_on_d;
                rgb_q      <= rgb_d;
                pixel_x_q  <= h_cnt;
                pixel_y_q  <= v_cnt;
            end
        end
    end

    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign video_on   = video_on_q;
    assign rgb        = rgb_q;
    assign pixel_x    = pixel_x_q;
    assign pixel_y    = pixel_y_q;
    assign pixel_tick = pixel_tick_q;
    assign frame_end  = frame_end_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Self-checking bench for vga_pattern_gen on a shrunken raster, compared
// against an arithmetic model that derives position from elapsed enabled clks.
module tb_vga_pattern_gen;

    localparam int   HA   = 32;
    localparam int   HFP  = 4;
    localparam int   HSW  = 8;
    localparam int   HBP  = 4;
    localparam int   VA   = 24;
    localparam int   VFP  = 2;
    localparam int   VSW  = 2;
    localparam int   VBP  = 4;
    localparam logic HS_POL = 1'b0;
    localparam logic VS_POL = 1'b0;
    localparam int   DIV  = 2;
    localparam int   CHW  = 2;
    localparam int   CHK  = 3;
    localparam int   CW   = 10;
    localparam int   HT   = HA + HFP + HSW + HBP;
    localparam int   VT   = VA + VFP + VSW + VBP;
    localparam int   NPIX = HT * VT;
    localparam int   VW   = 3 + 3 * CHW + 2 * CW + 2;
    localparam logic [VW-1:0] RST_V = {~HS_POL, ~VS_POL, {(VW - 2){1'b0}}};

    logic            clk = 1'b0;
    logic            reset, en;
    logic [1:0]      mode;
    logic [2:0]      sw;
    logic            hsync, vsync, video_on, pixel_tick, frame_end;
    logic [3*CHW-1:0] rgb;
    logic [CW-1:0]   pixel_x, pixel_y;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int              m_c;
    logic [1:0]      m_mode;
    logic            e_hs, e_vs, e_von, e_pt, e_fe;
    logic [3*CHW-1:0] e_rgb;
    logic [CW-1:0]   e_x, e_y;

    logic [VW-1:0] act_v, exp_v;
    assign act_v = {hsync, vsync, video_on, rgb, pixel_x, pixel_y, pixel_tick, frame_end};
    assign exp_v = {e_hs, e_vs, e_von, e_rgb, e_x, e_y, e_pt, e_fe};

    vga_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .HS_POL(HS_POL), .VS_POL(VS_POL), .CLK_DIV(DIV),
        .CH_W(CHW), .CHK_LOG2(CHK), .CW(CW)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .sw(sw),
        .hsync(hsync), .vsync(vsync), .video_on(video_on), .rgb(rgb),
        .pixel_x(pixel_x), .pixel_y(pixel_y),
        .pixel_tick(pixel_tick), .frame_end(frame_end)
    );

    always #5 clk = ~clk;

    function automatic logic [3*CHW-1:0] expand(input logic [2:0] c);
        return {{CHW{c[2]}}, {CHW{c[1]}}, {CHW{c[0]}}};
    endfunction

    // Predict the outputs for this edge from the inputs now applied, then advance one clk.
    task automatic cyc();
        int pix, h, v;
        bit tk, vis;
        logic [2:0] c3;
        if (reset) begin
            m_c = 0; m_mode = 2'd0;
            e_hs = ~HS_POL; e_vs = ~VS_POL; e_von = 1'b0; e_rgb = '0;
            e_x = '0; e_y = '0; e_pt = 1'b0; e_fe = 1'b0;
        end else if (!en) begin
            e_pt = 1'b0; e_fe = 1'b0;
        end else begin
            pix = m_c / DIV;
            h   = pix % HT;
            v   = (pix / HT) % VT;
            tk  = (m_c % DIV) == DIV - 1;
            vis = (h < HA) && (v < VA);
            e_x = CW'(h); e_y = CW'(v); e_von = vis;
            e_hs = (h >= HA + HFP && h < HA + HFP + HSW) ? HS_POL : ~HS_POL;
            e_vs = (v >= VA + VFP && v < VA + VFP + VSW) ? VS_POL : ~VS_POL;
            case (m_mode)
                2'd1:    c3 = 3'((h * 8) / HA);
                2'd2:    c3 = ((((h >> CHK) ^ (v >> CHK)) & 1) != 0) ? 3'b111 : 3'b000;
                2'd3:    c3 = sw;
                default: c3 = 3'b000;
            endcase
            e_rgb = vis ? expand(c3) : '0;
            e_pt  = tk;
            e_fe  = tk && (h == HT - 1) && (v == VT - 1);
            if (e_fe) m_mode = mode;
            m_c++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b0; mode = 2'd3; sw = 3'd7;
        cyc(); cyc();
        n_checks++;
        if (act_v !== RST_V) begin
            n_fail++; $display("FAIL reset_values: got %h want %h", act_v, RST_V);
        end
        en = 1'b1;
        cyc();
        n_checks++;
        if (act_v !== exp_v) begin
            n_fail++; $display("FAIL reset_over_en: got %h want %h", act_v, exp_v);
        end
        reset = 1'b0; mode = 2'd0;
    endtask

    task automatic test_frame_timing();
        int n, last_tk;
        bit got;
        n = 0; last_tk = 0; got = 0;
        en = 1'b1; mode = 2'd0;
        while (!got && n < NPIX * DIV + 16) begin
            sw = 3'($urandom);
            cyc(); n++;
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++; $display("FAIL frame_vec: got %h want %h", act_v, exp_v);
            end
            if (pixel_tick === 1'b1) begin
                n_checks++;
                if (n - last_tk != DIV) begin
                    n_fail++; $display("FAIL tick_period: got %0d want %0d", n - last_tk, DIV);
                end
                last_tk = n;
            end
            if (frame_end === 1'b1) got = 1;
        end
        n_checks++;
        if (!got || n != NPIX * DIV) begin
            n_fail++; $display("FAIL first_frame_end: got %0d clks (seen=%0d) want %0d", n, got, NPIX * DIV);
        end
    endtask

    task automatic test_sync();
        int hrun, vrun, hruns, vruns;
        logic phs, pvs;
        hrun = 0; vrun = 0; hruns = 0; vruns = 0;
        phs = hsync; pvs = vsync;
        for (int i = 0; i < NPIX * DIV; i++) begin
            sw = 3'($urandom);
            cyc();
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++; $display("FAIL sync_vec: got %h want %h", act_v, exp_v);
            end
            if (hsync === HS_POL) begin
                if (phs !== HS_POL) begin
                    n_checks++;
                    if (pixel_x !== CW'(HA + HFP)) begin
                        n_fail++; $display("FAIL hsync_start_x: got %0d want %0d", pixel_x, HA + HFP);
                    end
                end
                hrun++;
            end else if (phs === HS_POL) begin
                n_checks++;
                if (hrun != HSW * DIV) begin
                    n_fail++; $display("FAIL hsync_width: got %0d want %0d", hrun, HSW * DIV);
                end
                hrun = 0; hruns++;
            end
            if (vsync === VS_POL) begin
                if (pvs !== VS_POL) begin
                    n_checks++;
                    if (pixel_y !== CW'(VA + VFP) || pixel_x !== '0) begin
                        n_fail++; $display("FAIL vsync_start: got (%0d,%0d) want (0,%0d)", pixel_x, pixel_y, VA + VFP);
                    end
                end
                vrun++;
            end else if (pvs === VS_POL) begin
                n_checks++;
                if (vrun != VSW * HT * DIV) begin
                    n_fail++; $display("FAIL vsync_width: got %0d want %0d", vrun, VSW * HT * DIV);
                end
                vrun = 0; vruns++;
            end
            phs = hsync; pvs = vsync;
        end
        n_checks++;
        if (hruns != VT || vruns != 1) begin
            n_fail++; $display("FAIL sync_pulse_count: got h=%0d v=%0d want h=%0d v=1", hruns, vruns, VT);
        end
    endtask

    task automatic run_to_frame_end(input string tag);
        int n;
        n = 0;
        do begin
            cyc(); n++;
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++; $display("FAIL %s_vec: got %h want %h", tag, act_v, exp_v);
            end
        end while (frame_end !== 1'b1 && n < NPIX * DIV + 16);
        n_checks++;
        if (frame_end !== 1'b1) begin
            n_fail++; $display("FAIL %s_frame_end_timeout: got %b want 1", tag, frame_end);
        end
    endtask

    task automatic test_bars();
        int hits, n;
        logic [3*CHW-1:0] want;
        mode = 2'd1; sw = 3'd5;
        run_to_frame_end("bars_latch");
        hits = 0; n = 0;
        while (pixel_y !== CW'(2) && n < 3 * HT * DIV) begin
            cyc(); n++;
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++; $display("FAIL bars_vec: got %h want %h", act_v, exp_v);
            end
            if (pixel_y === CW'(1) && (pixel_x === CW'(3) || pixel_x === CW'(4) ||
                                       pixel_x === CW'(HA - 1) || pixel_x === CW'(HA))) begin
                if (pixel_x === CW'(3))           want = expand(3'd0);
                else if (pixel_x === CW'(4))      want = expand(3'd1);
                else if (pixel_x === CW'(HA - 1)) want = expand(3'd7);
                else                              want = '0;
                hits++;
                n_checks++;
                if (rgb !== want) begin
                    n_fail++; $display("FAIL bar_x%0d: got %h want %h", pixel_x, rgb, want);
                end
            end
        end
        n_checks++;
        if (hits != 4 * DIV) begin
            n_fail++; $display("FAIL bar_spot_hits: got %0d want %0d", hits, 4 * DIV);
        end
    endtask

    task automatic test_mode_switch();
        int n, solid_hits, chk_hits;
        logic [3*CHW-1:0] want;
        mode = 2'd3; sw = 3'($urandom_range(1, 6));
        run_to_frame_end("solid_latch");
        n = 0;
        while (pixel_y !== CW'(5) && n < NPIX * DIV) begin
            cyc(); n++;
        end
        mode = 2'd2;
        solid_hits = 0; n = 0;
        do begin
            cyc(); n++;
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++; $display("FAIL switch_vec: got %h want %h", act_v, exp_v);
            end
            if (video_on === 1'b1) begin
                solid_hits++;
                n_checks++;
                if (rgb !== expand(sw)) begin
                    n_fail++; $display("FAIL solid_persist: got %h want %h", rgb, expand(sw));
                end
            end
        end while (frame_end !== 1'b1 && n < NPIX * DIV + 16);
        n_checks++;
        if (frame_end !== 1'b1 || solid_hits == 0) begin
            n_fail++; $display("FAIL switch_frame: got fe=%b hits=%0d want fe=1 hits>0", frame_end, solid_hits);
        end
        chk_hits = 0; n = 0;
        while (pixel_y !== CW'(9) && n < 10 * HT * DIV) begin
            cyc(); n++;
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++; $display("FAIL check_vec: got %h want %h", act_v, exp_v);
            end
            if ((pixel_x === CW'(0) && pixel_y === CW'(0)) ||
                (pixel_x === CW'(8) && pixel_y === CW'(0)) ||
                (pixel_x === CW'(8) && pixel_y === CW'(8))) begin
                want = (pixel_y === CW'(0) && pixel_x === CW'(8)) ? expand(3'd7) : '0;
                chk_hits++;
                n_checks++;
                if (rgb !== want) begin
                    n_fail++; $display("FAIL check_cell(%0d,%0d): got %h want %h", pixel_x, pixel_y, rgb, want);
                end
            end
        end
        n_checks++;
        if (chk_hits != 3 * DIV) begin
            n_fail++; $display("FAIL check_spot_hits: got %0d want %0d", chk_hits, 3 * DIV);
        end
    endtask

    task automatic test_en_pause();
        int n;
        logic [CW-1:0] sx, sy;
        logic [3*CHW-1:0] srgb;
        mode = 2'd3; sw = 3'd6;
        run_to_frame_end("pause_latch");
        n = 0;
        while (!(pixel_x === CW'(10) && pixel_y === CW'(3)) && n < NPIX * DIV) begin
            cyc(); n++;
        end
        sx = pixel_x; sy = pixel_y; srgb = rgb;
        en = 1'b0;
        for (int i = 0; i < 50; i++) begin
            sw = 3'($urandom);
            cyc();
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++; $display("FAIL pause_vec: got %h want %h", act_v, exp_v);
            end
            n_checks++;
            if (pixel_x !== sx || pixel_y !== sy || rgb !== srgb || pixel_tick !== 1'b0) begin
                n_fail++; $display("FAIL pause_frozen: got (%0d,%0d,%h,%b) want (%0d,%0d,%h,0)",
                                   pixel_x, pixel_y, rgb, pixel_tick, sx, sy, srgb);
            end
        end
        en = 1'b1;
        n = 0;
        while (pixel_x === sx && n < 2 * DIV + 2) begin
            cyc(); n++;
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++; $display("FAIL resume_vec: got %h want %h", act_v, exp_v);
            end
        end
        n_checks++;
        if (pixel_x !== sx + 1'b1 || pixel_y !== sy) begin
            n_fail++; $display("FAIL resume_pos: got (%0d,%0d) want (%0d,%0d)", pixel_x, pixel_y, sx + 1'b1, sy);
        end
    endtask

    task automatic test_reset_midframe();
        int n;
        n = 0;
        while (!(pixel_x === CW'(20) && pixel_y === CW'(10)) && n < NPIX * DIV) begin
            cyc(); n++;
        end
        reset = 1'b1;
        cyc();
        n_checks++;
        if (act_v !== RST_V) begin
            n_fail++; $display("FAIL midframe_reset: got %h want %h", act_v, RST_V);
        end
        reset = 1'b0;
        cyc();
        n_checks++;
        if (pixel_x !== '0 || pixel_y !== '0 || video_on !== 1'b1) begin
            n_fail++; $display("FAIL restart_origin: got (%0d,%0d,von=%b) want (0,0,von=1)", pixel_x, pixel_y, video_on);
        end
        n = 1;
        while (frame_end !== 1'b1 && n < NPIX * DIV + 16) begin
            cyc(); n++;
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++; $display("FAIL restart_vec: got %h want %h", act_v, exp_v);
            end
        end
        n_checks++;
        if (frame_end !== 1'b1 || n != NPIX * DIV) begin
            n_fail++; $display("FAIL restart_frame_len: got %0d clks want %0d", n, NPIX * DIV);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 8000; i++) begin
            en    = ($urandom_range(0, 9) != 0);
            mode  = 2'($urandom);
            sw    = 3'($urandom);
            reset = ($urandom_range(0, 2999) == 0);
            cyc();
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++; $display("FAIL random_vec: got %h want %h", act_v, exp_v);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; mode = 2'd0; sw = 3'd0;
        test_reset();
        test_frame_timing();
        test_sync();
        test_bars();
        test_mode_switch();
        test_en_pause();
        test_reset_midframe();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_pattern_gen.md
VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- H_ACTIVE 640, visible pixels per line
- H_FP 16, H_SYNC 96, H_BP 48: horizontal porch and sync widths in pixels
- V_ACTIVE 480, visible lines
- V_FP 10, V_SYNC 2, V_BP 33: vertical porch and sync widths in lines
- HS_POL 0, VS_POL 0: sync active level
- CLK_DIV 2, clk cycles per pixel (>=1)
- CH_W 1, bits per colour channel
- CHK_LOG2 5, log2 of checkerboard cell size
- CW 10, counter/coordinate width
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk  in  1  sole clock
- reset  in  1  synchronous, active-high
- en  in  1  count enable; low freezes all timing state
- mode  in  2  pattern select: 0 black, 1 colour bars, 2 checkerboard, 3 solid
- sw  in  3  solid colour select {r,g,b}
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- video_on  out  1  pixel is in the visible area
- rgb  out  3*CH_W  pixel colour {R,G,B}
- pixel_x  out  CW  current column
- pixel_y  out  CW  current row
- pixel_tick  out  1  one-clk strobe per pixel
- frame_end  out  1  one-clk strobe on the last pixel of a frame

Function
REQ-003 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
REQ-004 Divider counts 0..CLK_DIV-1 while en=1; the internal tick fires when the divider equals CLK_DIV-1 and en=1; with CLK_DIV=1 the tick fires every en cycle.
REQ-005 On a tick, h_cnt increments and wraps from H_TOTAL-1 to 0; on that wrap v_cnt increments and wraps from V_TOTAL-1 to 0.
REQ-006 With en=0, divider, h_cnt, v_cnt and the latched mode are held, pixel_tick and frame_end are 0, and all other outputs hold.
REQ-007 Decodes, from the counters:
- hsync active when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC
- vsync active when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC
- video_on = h_cnt<H_ACTIVE and v_cnt<V_ACTIVE
REQ-008 Active sync level = HS_POL/VS_POL; inactive level = the complement.
REQ-009 All outputs are registered and share exactly 1 clk latency after the counter state they describe; pixel_x/pixel_y are registered copies of h_cnt/v_cnt.
REQ-010 Patterns (each channel is replicated to CH_W bits):
- Mode 1: bar k = pixel_x*8/H_ACTIVE (H_ACTIVE multiple of 8); {r,g,b} = k[2:0]
- Mode 2: all channels all-ones when x[CHK_LOG2]^y[CHK_LOG2] = 1, else zero
- Mode 3: {r,g,b} = sw
- Mode 0: zero
REQ-011 rgb = 0 whenever video_on = 0, regardless of mode.
REQ-012 mode is sampled into the latched mode only on the tick where h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1; a mode change mid-frame takes effect at the next frame's pixel (0,0).
REQ-013 sw is not latched: it takes effect on the next pixel.
REQ-014 frame_end = 1 for exactly the clk after the tick at (H_TOTAL-1, V_TOTAL-1).
REQ-015 pixel_tick = 1 for exactly the clk after each internal tick.

Reset
REQ-016 When reset=1 on a clk edge:
- divider, h_cnt and v_cnt are 0
- latched mode is 0
- hsync and vsync are at their inactive level
- video_on, rgb, pixel_x, pixel_y, pixel_tick and frame_end are 0
REQ-017 Reset overrides en.
REQ-018 Reset asserted mid-frame restarts the timing at (0,0) on the first clk after its release.

Structure
REQ-019 A shared package vga_pkg holds the default timing constants, the mode encodings (MODE_BLACK, MODE_BARS, MODE_CHECK, MODE_SOLID) and the derived H_TOTAL/V_TOTAL functions.
REQ-020 Divider and h/v counters live in one sub-module vga_sync_counter (outputs h_cnt, v_cnt, tick); vga_pattern_gen holds the decode, pattern logic and output registers.

Verification
REQ-021 Default params, en=1, mode=0 from reset → first frame_end 840000 clks after reset release; pixel_tick period 2 clks.
REQ-022 Default params → hsync low for 192 clks starting when pixel_x=656; vsync low for 2 lines starting when pixel_y=490; both high at all other times.
REQ-023 mode=1 → rgb=0 at pixel_x=79, rgb=1 at pixel_x=80, rgb=7 at pixel_x=639, rgb=0 at pixel_x=640 (blanking).
REQ-024 mode switched from 3 to 2 at pixel_y=100 → solid colour continues to the end of the frame; checkerboard starts at (0,0) of the next frame, with (32,0)=all-ones and (32,32)=0.
REQ-025 en=0 held for 50 clks mid-line → pixel_x, pixel_y and rgb frozen and no pixel_tick; counting resumes from the same pixel.
REQ-026 reset pulsed 1 clk at pixel (300,200) → next clk all outputs at reset values; the timing restarts at (0,0) with the frame_end interval unchanged.
